work_packet_rx: RTL and testbench

//  Assembles the byte stream from the UART receiver into one work packet: 32-byte midstate + 12-byte data2 tail.

---
 rtl/work_packet_rx.sv | 105 ++++++++++
 tb/tb_work_packet_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/work_packet_rx.sv
// Assembles UART bytes into one work packet (midstate + data2 tail) and publishes it
// atomically with a one-cycle start pulse; stale partial packets are dropped after an idle gap.
module work_packet_rx #(
  parameter int MIDSTATE_BYTES = 32,
  parameter int DATA_BYTES     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         start,
  output logic         rx_busy,
  output logic         timeout_err
);

  localparam int N  = MIDSTATE_BYTES + DATA_BYTES;
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = 8 * (N - 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [TW-1:0] timer, timer_next;
  logic          last_byte, timed_out;
  // The final byte is taken straight from rx_data, so the shadow only holds N-1 bytes.
  logic [SW-1:0] shadow;

  // NOTE: every signal assigned in this block gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    timer_next = timer;
    last_byte  = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          count_next = CW'(1);
          timer_next = '0;
          state_next = RECV;
        end
      end
      RECV: begin
        if (rx_valid) begin
          // A byte arriving in the timeout cycle wins over the timeout.
          timer_next = '0;
          if (count == LAST_IDX) begin
            last_byte  = 1'b1;
            count_next = '0;
            state_next = IDLE;
          end else begin
            count_next = count + CW'(1);
          end
        end else if (timer == TIMER_MAX) begin
          timed_out  = 1'b1;
          count_next = '0;
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      timer       <= '0;
      start       <= 1'b0;
      timeout_err <= 1'b0;
      midstate    <= '0;
      data2       <= '0;
      // NOTE: the shadow buffer is reset explicitly, so it maps to flops rather than RAM.
      shadow      <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      timer       <= timer_next;
      start       <= last_byte;
      timeout_err <= timed_out;
      if (rx_valid && count != LAST_IDX)
        shadow[{count, 3'b000} +: 8] <= rx_data;
      if (last_byte) begin
        midstate <= shadow[8*MIDSTATE_BYTES-1:0];
        data2    <= {{(256 - 8*DATA_BYTES){1'b0}}, rx_data, shadow[SW-1:8*MIDSTATE_BYTES]};
      end
    end
  end

  assign rx_busy = (count != '0);

endmodule

// File: tb/tb_work_packet_rx.sv
// Directed bench for work_packet_rx: full packets, clock command, timeout, byte on the
// timeout cycle, back-to-back packets and reset mid-packet.
module tb_work_packet_rx;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [255:0] midstate, data2;
  logic         start, rx_busy, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]   pkt [44];
  logic [255:0] exp_mid, exp_d2;

  int cyc = 0;
  int start_pulses = 0;
  int err_pulses = 0;
  int last_start_cyc = 0;
  int prev_start_cyc = 0;

  work_packet_rx #(
    .MIDSTATE_BYTES(32),
    .DATA_BYTES(12),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .midstate(midstate),
    .data2(data2),
    .start(start),
    .rx_busy(rx_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start) begin
      start_pulses   <= start_pulses + 1;
      prev_start_cyc <= last_start_cyc;
      last_start_cyc <= cyc;
    end
    if (timeout_err) err_pulses <= err_pulses + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one byte for exactly one cycle; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) send_byte(pkt[k]);
  endtask

  task automatic build_expect();
    exp_mid = '0;
    exp_d2  = '0;
    for (int k = 0; k < 32; k++) exp_mid[8*k +: 8] = pkt[k];
    for (int k = 0; k < 12; k++) exp_d2[8*k +: 8] = pkt[32+k];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] prev_mid, prev_d2;
    logic [7:0]   cmd [12];
    int hits, first_hit, starts_seen, s0, e0;

    // Reset state
    idle(2);
    check("rst_midstate", midstate, '0);
    check("rst_data2", data2, '0);
    check("rst_start", start, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;
    idle(1);

    // 1. Bytes 00..2B back to back
    for (int k = 0; k < 44; k++) pkt[k] = 8'(k);
    build_expect();
    send_range(0, 42);
    check("t1_start_early", start, 0);
    check("t1_busy_mid", rx_busy, 1);
    send_byte(pkt[43]);
    check("t1_start", start, 1);
    check("t1_busy_done", rx_busy, 0);
    check("t1_mid_lo", midstate[7:0], 8'h00);
    check("t1_mid_hi", midstate[255:248], 8'h1F);
    check("t1_d2_lo", data2[7:0], 8'h20);
    check("t1_d2_hi", data2[95:88], 8'h2B);
    check("t1_d2_pad", data2[255:96], '0);
    check("t1_mid", midstate, exp_mid);
    check("t1_d2", data2, exp_d2);
    idle(1);
    check("t1_start_drop", start, 0);
    check("t1_mid_hold", midstate, exp_mid);

    // 2. Clock command
    cmd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h32, 8'h68, 8'h00};
    for (int k = 0; k < 32; k++) pkt[k] = 8'h00;
    for (int k = 0; k < 12; k++) pkt[32+k] = cmd[k];
    build_expect();
    send_range(0, 43);
    check("t2_start", start, 1);
    check("t2_d2_ff", data2[63:32], 32'hFFFF_FFFF);
    check("t2_d2_32", data2[79:72], 8'h32);
    check("t2_d2_68", data2[87:80], 8'h68);
    check("t2_mid", midstate, '0);
    check("t2_d2", data2, exp_d2);
    idle(3);
    prev_mid = midstate;
    prev_d2  = data2;

    // 3. Ten bytes then a long idle gap
    for (int k = 0; k < 44; k++) pkt[k] = 8'h5A;
    send_range(0, 9);
    hits = 0;
    first_hit = -1;
    starts_seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (timeout_err) begin
        hits++;
        if (first_hit < 0) first_hit = i;
      end
      if (start) starts_seen++;
      if (i == 14) check("t3_busy_before", rx_busy, 1);
    end
    check("t3_timeout_pulses", hits, 1);
    check("t3_timeout_cycle", first_hit, 15);
    check("t3_no_start", starts_seen, 0);
    check("t3_busy_after", rx_busy, 0);
    check("t3_mid_kept", midstate, prev_mid);
    check("t3_d2_kept", data2, prev_d2);
    for (int k = 0; k < 44; k++) pkt[k] = 8'(8'hA0 + k);
    build_expect();
    send_range(0, 43);
    check("t3_start", start, 1);
    check("t3_mid", midstate, exp_mid);
    check("t3_d2", data2, exp_d2);
    idle(2);

    // 4. Byte strobed on the timeout cycle
    for (int k = 0; k < 44; k++) pkt[k] = 8'(k) ^ 8'h55;
    build_expect();
    e0 = err_pulses;
    send_range(0, 9);
    idle(15);
    check("t4_busy_pre", rx_busy, 1);
    check("t4_no_err_pre", timeout_err, 0);
    send_byte(pkt[10]);
    check("t4_no_err", timeout_err, 0);
    check("t4_busy", rx_busy, 1);
    send_range(11, 43);
    check("t4_start", start, 1);
    check("t4_mid", midstate, exp_mid);
    check("t4_d2", data2, exp_d2);
    idle(2);
    check("t4_err_count", err_pulses - e0, 0);

    // 5. Back-to-back packets, second one starting in the start cycle
    s0 = start_pulses;
    for (int k = 0; k < 44; k++) pkt[k] = 8'(3 * k);
    build_expect();
    send_range(0, 43);
    check("t5a_start", start, 1);
    check("t5a_mid", midstate, exp_mid);
    check("t5a_d2", data2, exp_d2);
    for (int k = 0; k < 44; k++) pkt[k] = 8'(8'hFF - k);
    send_byte(pkt[0]);
    check("t5b_busy_first", rx_busy, 1);
    send_range(1, 43);
    build_expect();
    check("t5b_start", start, 1);
    check("t5b_mid", midstate, exp_mid);
    check("t5b_d2", data2, exp_d2);
    idle(2);
    check("t5_start_count", start_pulses - s0, 2);
    check("t5_start_gap", last_start_cyc - prev_start_cyc, 44);

    // 6. Reset mid-packet
    for (int k = 0; k < 44; k++) pkt[k] = 8'hEE;
    send_range(0, 20);
    reset_n = 1'b0;
    #1;
    check("t6_rst_mid", midstate, '0);
    check("t6_rst_d2", data2, '0);
    check("t6_rst_busy", rx_busy, 0);
    check("t6_rst_start", start, 0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    s0 = start_pulses;
    for (int k = 0; k < 44; k++) pkt[k] = 8'(8'h10 + k);
    build_expect();
    send_range(0, 42);
    check("t6_no_early_start", start, 0);
    send_byte(pkt[43]);
    check("t6_start", start, 1);
    check("t6_mid", midstate, exp_mid);
    check("t6_d2", data2, exp_d2);
    idle(3);
    check("t6_start_count", start_pulses - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
